wb_stage: RTL and testbench

Parametrised write-back stage placed between the memory stage and the register file / instruction fetch. Each cycle it accepts at most one retiring instruction and selects the write-back value from ALU result, load data or PC+4. With the load extender compiled in, it aligns and sign/zero-extends sub-word loads. It waits for late load data and owns the architectural PC register and retired-instruction counter.

---
 rtl/wb_stage.sv | 178 +++++++++++++++++
 tb/tb_wb_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU/load/link value, stalls on late load data, owns PC and instret.
// Optional load aligner/extender enabled by defining WB_LOAD_EXT_EN.
module wb_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int PC_STEP = 4,
   localparam int RA = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [RA-1:0]   rd_i,
   input  logic            rd_we_i,
   input  logic [1:0]      wb_sel_i,
   input  logic            pc_sel_i,
   input  logic [XLEN-1:0] alu_i,
   input  logic [XLEN-1:0] mem_i,
   input  logic            mem_valid_i,
   input  logic [1:0]      ld_size_i,
   input  logic            ld_unsigned_i,
   output logic            rf_we_o,
   output logic [RA-1:0]   rf_addr_o,
   output logic [XLEN-1:0] rf_data_o,
   output logic [XLEN-1:0] pc_o,
   output logic [63:0]     instret_o
);
   localparam int OW = $clog2(XLEN/8);

   typedef enum logic {IDLE, WAIT_MEM} state_t;
   state_t state_reg, state_next;

   logic [RA-1:0]   hold_rd_reg;
   logic            hold_we_reg;
   logic            hold_pcsel_reg;
   logic [XLEN-1:0] hold_alu_reg;

   logic            accept, commit, stall_go;
   logic [RA-1:0]   c_rd;
   logic            c_we, c_pcsel;
   logic [1:0]      c_wbsel;
   logic [XLEN-1:0] c_alu, mem_val, wb_val, pc_next, pc_seq;

   assign ready_o = !rst && (state_reg == IDLE);
   assign accept  = valid_i && ready_o;
   assign pc_seq  = pc_o + XLEN'(PC_STEP);

   // Commit fields come from live inputs in IDLE and from the hold registers in WAIT_MEM.
   always_comb begin
      state_next = state_reg;
      commit     = 1'b0;
      stall_go   = 1'b0;
      c_rd       = rd_i;
      c_we       = rd_we_i;
      c_wbsel    = wb_sel_i;
      c_pcsel    = pc_sel_i;
      c_alu      = alu_i;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (wb_sel_i == 2'b01 && !mem_valid_i) begin
                  state_next = WAIT_MEM;
                  stall_go   = 1'b1;
               end else begin
                  commit = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            c_rd    = hold_rd_reg;
            c_we    = hold_we_reg;
            c_wbsel = 2'b01;
            c_pcsel = hold_pcsel_reg;
            c_alu   = hold_alu_reg;
            if (mem_valid_i) begin
               commit     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef WB_LOAD_EXT_EN
   logic [1:0]      hold_size_reg;
   logic            hold_uns_reg;
   logic [1:0]      c_size;
   logic            c_uns;
   logic [OW-1:0]   off;
   logic [7:0]      lane [XLEN/8];
   logic [XLEN-1:0] shifted, word_ext;
   logic            unused_ext;

   assign c_size     = (state_reg == WAIT_MEM) ? hold_size_reg : ld_size_i;
   assign c_uns      = (state_reg == WAIT_MEM) ? hold_uns_reg : ld_unsigned_i;
   assign off        = c_alu[OW-1:0];
   assign shifted    = mem_i >> {off, 3'b000};
   assign unused_ext = ^shifted;

   for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
      assign lane[gi] = mem_i[gi*8 +: 8];
   end

   if (XLEN > 32) begin : g_word64
      assign word_ext = {{(XLEN-32){~c_uns & shifted[31]}}, shifted[31:0]};
   end else begin : g_word32
      assign word_ext = shifted;
   end

   // Misaligned half/word loads fall through as the raw word.
   always_comb begin
      mem_val = mem_i;
      case (c_size)
         2'b00: mem_val = {{(XLEN-8){~c_uns & lane[off][7]}}, lane[off]};
         2'b01: if (!off[0]) mem_val = {{(XLEN-16){~c_uns & shifted[15]}}, shifted[15:0]};
         2'b10: if (off[1:0] == 2'b00) mem_val = word_ext;
         default: mem_val = mem_i;
      endcase
   end
`else
   logic unused_ok;
   assign unused_ok = ^{ld_size_i, ld_unsigned_i};
   assign mem_val   = mem_i;
`endif

   always_comb begin
      case (c_wbsel)
         2'b01:   wb_val = mem_val;
         2'b10:   wb_val = pc_seq;
         default: wb_val = c_alu;
      endcase
      pc_next = c_pcsel ? {c_alu[XLEN-1:1], 1'b0} : pc_seq;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         rf_we_o        <= 1'b0;
         rf_addr_o      <= '0;
         rf_data_o      <= '0;
         pc_o           <= RESET_PC;
         instret_o      <= '0;
         hold_rd_reg    <= '0;
         hold_we_reg    <= 1'b0;
         hold_pcsel_reg <= 1'b0;
         hold_alu_reg   <= '0;
      end else begin
         state_reg <= state_next;
         rf_we_o   <= commit && c_we && (c_rd != '0);
         if (stall_go) begin
            hold_rd_reg    <= rd_i;
            hold_we_reg    <= rd_we_i;
            hold_pcsel_reg <= pc_sel_i;
            hold_alu_reg   <= alu_i;
         end
         if (commit) begin
            rf_addr_o <= c_rd;
            rf_data_o <= wb_val;
            pc_o      <= pc_next;
            instret_o <= instret_o + 64'd1;
         end
      end
   end

`ifdef WB_LOAD_EXT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_size_reg <= '0;
         hold_uns_reg  <= 1'b0;
      end else if (stall_go) begin
         hold_size_reg <= ld_size_i;
         hold_uns_reg  <= ld_unsigned_i;
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios then random traffic against a behavioural retire model.
module tb_wb_stage;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int RA   = 5;
   localparam logic [31:0] RPC = 32'h0000_0080;

   logic clk = 1'b0;
   logic rst, valid_i, ready_o, rd_we_i, pc_sel_i, mem_valid_i, ld_unsigned_i;
   logic [RA-1:0] rd_i, rf_addr_o;
   logic [1:0] wb_sel_i, ld_size_i;
   logic [31:0] alu_i, mem_i, rf_data_o, pc_o;
   logic rf_we_o;
   logic [63:0] instret_o;

   wb_stage #(.XLEN(XLEN), .NREG(NREG), .RESET_PC(RPC), .PC_STEP(4)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
      .rd_i(rd_i), .rd_we_i(rd_we_i), .wb_sel_i(wb_sel_i), .pc_sel_i(pc_sel_i),
      .alu_i(alu_i), .mem_i(mem_i), .mem_valid_i(mem_valid_i),
      .ld_size_i(ld_size_i), .ld_unsigned_i(ld_unsigned_i),
      .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
      .pc_o(pc_o), .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference: architectural results plus one pending load awaiting its data.
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data, m_pc;
   logic [63:0] m_instret;
   bit          m_wait;
   logic [4:0]  p_rd;
   logic        p_we, p_pcsel, p_uns;
   logic [31:0] p_alu;
   logic [1:0]  p_size;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] load_value(input logic [31:0] w, input int off,
                                              input int size, input bit uns);
      logic [31:0] v;
`ifdef WB_LOAD_EXT_EN
      if (size == 0) begin
         v = (w >> (8*off)) & 32'hFF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
         return v;
      end
      if (size == 1) begin
         if (off % 2 == 1) return w;
         v = (w >> (8*off)) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
         return v;
      end
      v = w;
      return v;
`else
      v = w;
      return v;
`endif
   endfunction

   task automatic m_retire(input logic [4:0] rd, input logic we, input logic [1:0] wbsel,
                           input logic pcsel, input logic [31:0] alu, input logic [31:0] mem,
                           input logic [1:0] size, input logic uns);
      logic [31:0] val;
      if (wbsel == 2'd1)      val = load_value(mem, int'(alu % 4), int'(size), uns);
      else if (wbsel == 2'd2) val = m_pc + 32'd4;
      else                    val = alu;
      m_we      = we && (rd != 5'd0);
      m_addr    = rd;
      m_data    = val;
      m_pc      = pcsel ? (alu & ~32'd1) : m_pc + 32'd4;
      m_instret = m_instret + 64'd1;
   endtask

   task automatic m_step();
      if (rst) begin
         m_we = 0; m_addr = 0; m_data = 0; m_pc = RPC; m_instret = 0; m_wait = 0;
      end else if (!m_wait) begin
         m_we = 0;
         if (valid_i) begin
            if (wb_sel_i == 2'd1 && !mem_valid_i) begin
               m_wait = 1; p_rd = rd_i; p_we = rd_we_i; p_pcsel = pc_sel_i;
               p_alu = alu_i; p_size = ld_size_i; p_uns = ld_unsigned_i;
            end else begin
               m_retire(rd_i, rd_we_i, wb_sel_i, pc_sel_i, alu_i, mem_i, ld_size_i, ld_unsigned_i);
            end
         end
      end else if (mem_valid_i) begin
         m_wait = 0;
         m_retire(p_rd, p_we, 2'd1, p_pcsel, p_alu, mem_i, p_size, p_uns);
      end else begin
         m_we = 0;
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic [1:0] wbsel,
                        input logic pcsel, input logic [31:0] alu, input logic [31:0] mem,
                        input logic mv, input logic [1:0] size, input logic uns);
      valid_i = v; rd_i = rd; rd_we_i = we; wb_sel_i = wbsel; pc_sel_i = pcsel;
      alu_i = alu; mem_i = mem; mem_valid_i = mv; ld_size_i = size; ld_unsigned_i = uns;
   endtask

   // One clock: inputs are already driven after the falling edge.
   task automatic cycle();
      #1;
      chk("ready", ready_o, !rst && !m_wait);
      m_step();
      @(posedge clk);
      #1;
      chk("rf_we", rf_we_o, m_we);
      if (m_we) chk("rf_addr", rf_addr_o, m_addr);
      chk("rf_data", rf_data_o, m_data);
      chk("pc", pc_o, m_pc);
      chk("instret", instret_o, m_instret);
      $display("[TB] t=%0t rst=%0b v=%0b wb=%0d mv=%0b we=%0b rd=%0d data=%h pc=%h instret=%0d",
               $time, rst, valid_i, wb_sel_i, mem_valid_i, rf_we_o, rf_addr_o, rf_data_o, pc_o, instret_o);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_wait = 0;
      @(negedge clk);
      cycle();
      cycle();
      chk("reset_pc", pc_o, RPC);
      chk("reset_instret", instret_o, 64'd0);
      chk("reset_rf_data", rf_data_o, 32'd0);

      rst = 1'b0;
      drive(1, 5, 1, 2'd0, 0, 32'h1234, 32'h0, 0, 0, 0);
      cycle();
      chk("alu_we", rf_we_o, 1'b1);
      chk("alu_addr", rf_addr_o, 5'd5);
      chk("alu_data", rf_data_o, 32'h1234);
      chk("alu_pc", pc_o, RPC + 32'd4);
      chk("alu_instret", instret_o, 64'd1);

      drive(1, 0, 0, 2'd0, 1, 32'h100, 32'h0, 0, 0, 0);
      cycle();
      drive(1, 1, 1, 2'd2, 1, 32'h201, 32'h0, 1, 0, 0);
      cycle();
      chk("jal_link", rf_data_o, 32'h104);
      chk("jal_pc", pc_o, 32'h200);

      drive(1, 7, 1, 2'd1, 0, 32'h4000, 32'h0, 0, 2'd2, 0);
      cycle();
      drive(1, 9, 1, 2'd0, 0, 32'h5555, 32'h0, 0, 0, 0);
      cycle();
      chk("stall_no_we", rf_we_o, 1'b0);
      cycle();
      drive(1, 9, 1, 2'd0, 0, 32'h5555, 32'hDEAD_BEEF, 1, 0, 0);
      cycle();
      chk("late_load_data", rf_data_o, 32'hDEAD_BEEF);
      chk("late_load_addr", rf_addr_o, 5'd7);
      drive(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("late_load_single", rf_we_o, 1'b0);

`ifdef WB_LOAD_EXT_EN
      drive(1, 3, 1, 2'd1, 0, 32'h1002, 32'h80F0_7F00, 1, 2'd0, 0);
      cycle();
      chk("lb_off2", rf_data_o, 32'hFFFF_FFF0);
      drive(1, 3, 1, 2'd1, 0, 32'h1002, 32'h80F0_7F00, 1, 2'd1, 0);
      cycle();
      chk("lh_off2", rf_data_o, 32'hFFFF_80F0);
      drive(1, 3, 1, 2'd1, 0, 32'h1003, 32'h80F0_7F00, 1, 2'd0, 1);
      cycle();
      chk("lbu_off3", rf_data_o, 32'h0000_0080);
`endif

      drive(1, 0, 1, 2'd0, 0, 32'hABCD, 32'h0, 0, 0, 0);
      cycle();
      chk("x0_suppressed", rf_we_o, 1'b0);

      drive(1, 4, 1, 2'd1, 0, 32'h2000, 32'h0, 0, 2'd2, 0);
      cycle();
      rst = 1'b1;
      drive(0, 0, 0, 2'd0, 0, 0, 32'h1111_2222, 1, 0, 0);
      cycle();
      chk("rst_wait_pc", pc_o, RPC);
      chk("rst_wait_we", rf_we_o, 1'b0);
      rst = 1'b0;
      drive(0, 0, 0, 2'd0, 0, 0, 32'h0, 1, 0, 0);
      cycle();
      drive(1, 2, 1, 2'd0, 0, 32'h77, 32'h0, 0, 0, 0);
      #1;
      chk("ready_after_rst", ready_o, 1'b1);
      cycle();

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 1'($urandom),
               2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom, $urandom,
               $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 1'($urandom));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
